pc_fetch_stage: RTL and testbench

- PC register and instruction-fetch stage of the pipelined RV32 core; sits directly upstream of the next-PC logic.
- Drives cur_pc to the next-PC logic and consumes its next_pc/jump result.
- Fetches from instruction memory over a req/gnt/rvalid handshake and loads the IF/ID pipeline register.
- Handles stall (hold), redirect (flush and kill of the in-flight fetch), and buffers one response that arrives while ID is stalled.

---
 rtl/core_pkg.sv | 21 ++
 rtl/pc_fetch_stage_if_id_reg.sv | 51 +++++
 rtl/pc_fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the RV32 pipeline front end.
//   - XLEN          : datapath width
//   - NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0), also used
//                     by the decode flush path
//   - fetch_state_e : states of the instruction-fetch handshake FSM
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. A flush always wins, then a fresh delivery, then
//   stall-hold; an unstalled cycle with nothing to deliver inserts a bubble.
//
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     flush                 kill the IF/ID contents (redirect)
//     stall                 hold the current contents
//     load                  a fetched instruction is being delivered
//     load_pc, load_instr   PC and word of the delivered instruction
//     valid, pc, instr      registered IF/ID contents
// ---------------------------------------------------------------------------
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  // Priority: reset, flush, delivery, bubble; stall with none of these holds.
  // The PC field is left untouched on flush/bubble since valid=0 masks it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (!stall) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
//   PC register and instruction-fetch stage of the pipelined RV32 core.
//   Issues one fetch at a time over a req/gnt/rvalid handshake, loads the
//   IF/ID register, holds on stall, flushes and kills the in-flight fetch on
//   redirect, and parks one response in a skid buffer while ID is stalled.
//
//   Ports:
//     clk, rst_n                clock, synchronous active-low reset
//     next_pc, jump             next-PC logic result and redirect flag
//     stall                     hazard-unit hold request
//     cur_pc                    PC of the next fetch (to next-PC logic)
//     imem_req, imem_addr       fetch request and address
//     imem_gnt                  request accepted
//     imem_rvalid, imem_rdata   fetch response
//     if_id_valid/pc/instr      IF/ID pipeline register contents
//
//   Optional build macro FETCH_PERF_EN adds perf_fetch_cnt (deliveries) and
//   perf_kill_cnt (discarded responses and dropped skid-buffer entries).
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [core_pkg::XLEN-1:0] next_pc,
  input  logic                     jump,
  input  logic                     stall,
  output logic [core_pkg::XLEN-1:0] cur_pc,
  output logic                     imem_req,
  output logic [core_pkg::XLEN-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [core_pkg::XLEN-1:0] imem_rdata,
  output logic                     if_id_valid,
  output logic [core_pkg::XLEN-1:0] if_id_pc,
  output logic [core_pkg::XLEN-1:0] if_id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_kill_cnt
`endif
);

  import core_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] skid_buf;
  logic            kill;

  logic            deliver;
  logic [XLEN-1:0] deliver_instr;
  logic            discard;

  // Gated by rst_n so no request escapes during the reset cycle itself.
  assign imem_req  = (state == S_REQ) && rst_n;
  assign imem_addr = cur_pc;

  // Decide what this cycle does with a response or the skid buffer. A
  // response is discarded if its fetch was killed earlier or a redirect
  // lands in the same cycle; a redirect also drops a parked buffer.
  always_comb begin
    deliver       = 1'b0;
    deliver_instr = skid_buf;
    discard       = 1'b0;
    case (state)
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill || jump) begin
            discard = 1'b1;
          end else if (!stall) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
          end
        end
      end
      S_HOLD: begin
        if (jump) begin
          discard = 1'b1;
        end else if (!stall) begin
          deliver = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM, PC and skid buffer. The PC advances only on grant unless a
  // redirect arrives, which updates it from any state. A redirect while a
  // fetch is outstanding sets kill so the later response is thrown away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_REQ;
      cur_pc   <= RESET_PC;
      fetch_pc <= RESET_PC;
      kill     <= 1'b0;
      skid_buf <= NOP_INSTR;
    end else begin
      if (jump) begin
        cur_pc <= next_pc;
      end
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            fetch_pc <= cur_pc;
            cur_pc   <= next_pc;
            kill     <= jump;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (!(kill || jump) && stall) begin
              skid_buf <= imem_rdata;
              state    <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end else if (jump) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (jump || !stall) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (jump),
    .stall      (stall),
    .load       (deliver),
    .load_pc    (fetch_pc),
    .load_instr (deliver_instr),
    .valid      (if_id_valid),
    .pc         (if_id_pc),
    .instr      (if_id_instr)
  );

`ifdef FETCH_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (deliver) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (discard) begin
        perf_kill_cnt <= perf_kill_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_stage
//   Directed scenarios followed by randomized traffic for pc_fetch_stage.
//   A behavioural imem responder and a transaction-level reference model
//   (outstanding fetch, parked response, IF/ID slot) live in the bench.
// ---------------------------------------------------------------------------
module tb_pc_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        jump;
  logic        stall;
  logic [31:0] cur_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  always #5 clk = ~clk;

  pc_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .jump        (jump),
    .stall       (stall),
    .cur_pc      (cur_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: PC, at most one outstanding fetch, one parked
  // response, the IF/ID slot and event counts.
  logic [31:0] m_pc;
  bit          m_out_valid;
  bit          m_out_killed;
  logic [31:0] m_out_pc;
  bit          m_hold_valid;
  logic [31:0] m_hold_pc;
  bit          m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_kill_cnt;

  // Instruction memory responder state.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          mem_lat = 0;
  int          gnt_pct = 100;

  logic [31:0] got_pcs[$];
  logic [31:0] acc_log[$];
  logic [15:0] vhist;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] gotAt(input int i);
    return (i < got_pcs.size()) ? got_pcs[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] accAt(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_pc         = RESET_PC;
    m_out_valid  = 1'b0;
    m_out_killed = 1'b0;
    m_hold_valid = 1'b0;
    m_v          = 1'b0;
    m_ipc        = 32'h0;
    m_instr      = NOP;
    m_fetch_cnt  = 32'h0;
    m_kill_cnt   = 32'h0;
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the memory
  // and the model, then compare every observable output.
  task automatic applyStimulus(input bit rst_v, input bit stall_v, input bit jump_v,
                               input logic [31:0] target);
    bit          m_req;
    bit          granted;
    bit          resp;
    bit          rv;
    bit          mem_acc;
    bit          deliver;
    logic [31:0] acc_addr;
    logic [31:0] npc;
    logic [31:0] dpc;
    rst_n       = rst_v;
    stall       = stall_v;
    jump        = jump_v;
    npc         = jump_v ? target : m_pc + 32'd4;
    next_pc     = npc;
    rv          = mem_busy && (mem_wait == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? memWord(mem_addr) : $urandom;
    imem_gnt    = !mem_busy && ($urandom_range(99) < gnt_pct);
    #2;
    mem_acc  = imem_req && imem_gnt;
    acc_addr = imem_addr;
    m_req    = rst_v && !m_out_valid && !m_hold_valid;
    granted  = m_req && imem_gnt;
    resp     = rv && m_out_valid;
    @(posedge clk);
    #1;
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (mem_acc) begin
      mem_busy = 1'b1;
      mem_addr = acc_addr;
      mem_wait = mem_lat;
      acc_log.push_back(acc_addr);
    end
    if (!rst_v) begin
      resetModel();
    end else begin
      deliver = 1'b0;
      dpc     = 32'h0;
      if (resp) begin
        m_out_valid = 1'b0;
        if (m_out_killed || jump_v) m_kill_cnt++;
        else if (stall_v) begin
          m_hold_valid = 1'b1;
          m_hold_pc    = m_out_pc;
        end else begin
          deliver = 1'b1;
          dpc     = m_out_pc;
        end
      end else if (m_hold_valid) begin
        if (jump_v) begin
          m_hold_valid = 1'b0;
          m_kill_cnt++;
        end else if (!stall_v) begin
          m_hold_valid = 1'b0;
          deliver      = 1'b1;
          dpc          = m_hold_pc;
        end
      end else if (m_out_valid && jump_v) begin
        m_out_killed = 1'b1;
      end
      if (granted) begin
        m_out_valid  = 1'b1;
        m_out_pc     = m_pc;
        m_out_killed = jump_v;
      end
      if (granted || jump_v) m_pc = npc;
      if (jump_v) begin
        m_v     = 1'b0;
        m_instr = NOP;
      end else if (deliver) begin
        m_v     = 1'b1;
        m_ipc   = dpc;
        m_instr = memWord(dpc);
        m_fetch_cnt++;
      end else if (!stall_v) begin
        m_v     = 1'b0;
        m_instr = NOP;
      end
    end
    checkOutput("cur_pc", cur_pc, m_pc);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, rst_v && !m_out_valid && !m_hold_valid});
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
    checkOutput("if_id_instr", if_id_instr, m_instr);
    if (m_v) checkOutput("if_id_pc", if_id_pc, m_ipc);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
    checkOutput("perf_kill_cnt", perf_kill_cnt, m_kill_cnt);
`endif
    if (if_id_valid) got_pcs.push_back(if_id_pc);
    vhist = {vhist[14:0], if_id_valid};
  endtask

  task automatic runTo(input logic [31:0] pc, input string tag);
    int n = 0;
    while (!(m_pc == pc && !m_out_valid && !m_hold_valid) && n < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput(tag, cur_pc, pc);
  endtask

  task automatic runToValid(input logic [31:0] pc, input string tag);
    int n = 0;
    while (!(m_v && m_ipc == pc) && n < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput(tag, if_id_pc, pc);
  endtask

  initial begin
    logic [31:0] kill_before;
    logic [31:0] tgt;
    rst_n       = 1'b0;
    stall       = 1'b0;
    jump        = 1'b0;
    next_pc     = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mem_busy    = 1'b0;
    mem_wait    = 0;
    mem_addr    = 32'h0;
    vhist       = '0;
    resetModel();

    // Reset values and the zero-wait-state streaming pattern.
    $display("[TB] reset and streaming fetch");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_cur_pc", cur_pc, RESET_PC);
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("rst_if_id_pc", if_id_pc, 32'h0);
    checkOutput("rst_instr", if_id_instr, NOP);
    got_pcs.delete();
    acc_log.delete();
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s1_addr0", accAt(0), 32'h0);
    checkOutput("s1_addr1", accAt(1), 32'h4);
    checkOutput("s1_addr2", accAt(2), 32'h8);
    checkOutput("s1_count", got_pcs.size(), 32'd3);
    checkOutput("s1_pc0", gotAt(0), 32'h0);
    checkOutput("s1_pc1", gotAt(1), 32'h4);
    checkOutput("s1_pc2", gotAt(2), 32'h8);
    checkOutput("s1_valid_pattern", {26'b0, vhist[5:0]}, 32'b010101);

    // Response for 0x10 parked while ID is stalled.
    $display("[TB] stalled response");
    runTo(32'h0C, "s2_at_0c");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_pre_pc", if_id_pc, 32'h0C);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_held_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("s2_held_pc", if_id_pc, 32'h0C);
    checkOutput("s2_no_req", {31'b0, imem_req}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_deliver_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("s2_deliver_pc", if_id_pc, 32'h10);
    checkOutput("s2_deliver_instr", if_id_instr, memWord(32'h10));
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_no_dup", {31'b0, if_id_valid}, 32'h0);

    // Redirect while the fetch of 0x20 is outstanding.
    $display("[TB] redirect with fetch outstanding");
    runTo(32'h20, "s3_at_20");
    mem_lat = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    mem_lat = 0;
    kill_before = m_kill_cnt;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
    checkOutput("s3_cur_pc", cur_pc, 32'h200);
    checkOutput("s3_flush_valid", {31'b0, if_id_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_discard_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("s3_req", {31'b0, imem_req}, 32'h1);
    checkOutput("s3_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_EN
    checkOutput("s3_kill_cnt", perf_kill_cnt, kill_before + 32'd1);
`endif
    got_pcs.delete();
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_first_target", gotAt(0), 32'h200);

    // Reset while a fetch is outstanding; late response must be ignored.
    $display("[TB] reset with fetch outstanding");
    mem_lat = 3;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    mem_lat = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s6_rst_pc", cur_pc, RESET_PC);
    acc_log.delete();
    got_pcs.delete();
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s6_first_addr", accAt(0), RESET_PC);
    checkOutput("s6_first_pc", gotAt(0), RESET_PC);
    checkOutput("s6_count", got_pcs.size(), 32'd1);

    // Flush beats stall while IF/ID holds 0x30.
    $display("[TB] flush over stall");
    runToValid(32'h30, "s5_holds_30");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput("s5_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("s5_instr", if_id_instr, NOP);
    checkOutput("s5_cur_pc", cur_pc, 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect in the same cycle as the grant of 0x40.
    $display("[TB] redirect with grant");
    runTo(32'h40, "s4_at_40");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300);
    checkOutput("s4_cur_pc", cur_pc, 32'h300);
    got_pcs.delete();
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s4_first_pc", gotAt(0), 32'h300);

    // PC wrap from the top of the address space.
    $display("[TB] pc wrap");
    got_pcs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc0", gotAt(0), 32'hFFFF_FFFC);
    checkOutput("wrap_pc1", gotAt(1), 32'h0);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    gnt_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(2);
      tgt = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(7) == 0) tgt = 32'hFFFF_FFFC;
      applyStimulus($urandom_range(199) != 0, $urandom_range(3) == 0,
                    $urandom_range(9) == 0, tgt);
    end

    $display("[TB] model deliveries %0d, discards %0d", m_fetch_cnt, m_kill_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
